gpio_io_ctrl: RTL
=================

Name: gpio_io_ctrl

Overview:
- Parametrised successor to the board-level switch/LED path.
- Synchronises and debounces NUM_CH raw switch inputs, then produces per-channel debounced level, rise/fall pulses and sticky event flags.
- Drives NUM_CH LEDs, each under a per-channel mode: static, follow-switch, blink, or blink-while-event-pending.
- Sits directly under the top level, between the board pins and the user logic.

Parameters:
- NUM_CH, 4, number of switch and LED channels (1..32).
- SYNC_STAGES, 2, synchroniser flops per switch input (>=2).
- DEBOUNCE_CYCLES, 100000, consecutive stable cycles required to accept a new level (>=1); 1 ms at 100 MHz.
- BLINK_HALF_PERIOD, 25000000, cycles per blink phase (>=1); 250 ms at 100 MHz.

Ports:
- SYSTEMCLOCK  in  1  single system clock; all logic on its rising edge.
- PUSH_BUTTON_RESET_RAW  in  1  reset, asynchronous, active-high.
- gpio_switch  in  NUM_CH  raw asynchronous switch pins.
- event_clear  in  NUM_CH  write-1-to-clear strobe for sw_event.
- led_mode  in  2*NUM_CH  LED mode; bits [2i+1:2i] belong to channel i.
- led_value  in  NUM_CH  static LED level used in mode 0.
- sw_state  out  NUM_CH  debounced switch level.
- sw_rise  out  NUM_CH  one-cycle pulse on debounced 0->1.
- sw_fall  out  NUM_CH  one-cycle pulse on debounced 1->0.
- sw_event  out  NUM_CH  sticky flag: any debounced edge since last clear.
- gpio_led  out  NUM_CH  LED pins, registered.

Behaviour:
- Reset is asynchronous and active-high.
  - Assertion immediately clears every flop.
  - Release passes through an internal 2-flop release synchroniser; logic runs from the 2nd rising edge after deassertion.
  - All outputs are 0 in reset, and while the release synchroniser is still flushing.
  - Reset mid-debounce or mid-blink discards all progress; no pulse is generated on exit.
- Synchroniser: SYNC_STAGES flops per channel, reset to 0.
- Debounce, per channel: counter cnt of width clog2(DEBOUNCE_CYCLES)+1.
  - If sync == state: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: state <= sync and cnt <= 0.
  - Else: cnt <= cnt+1.
- Latency: a level first sampled on rising edge #1 appears on sw_state at edge #(SYNC_STAGES+DEBOUNCE_CYCLES), provided it stays stable.
- Glitches stable for fewer than DEBOUNCE_CYCLES synchronised cycles produce no change.
- sw_rise/sw_fall are registered and are high exactly in the first cycle the new sw_state is visible. They are never both high on one channel.
- sw_event:
  - Set on sw_rise|sw_fall.
  - Cleared by event_clear[i]=1.
  - If set and clear occur in the same cycle, set wins.
  - Holds its value otherwise.
- Blink generator: shared counter 0..BLINK_HALF_PERIOD-1. Phase bit toggles on each wrap; phase = 0 after reset.
- LED modes, per channel; gpio_led is registered, with 1 cycle latency from its inputs:
  - 0: led_value[i].
  - 1: sw_state[i].
  - 2: blink phase.
  - 3: blink phase AND sw_event[i]; 0 once the event is cleared.
- Mode changes take effect on the next edge without resetting the blink counter. All channels blink in phase.
- Counter widths are derived from parameters. Parameters violating their ranges trigger a $error at elaboration.

Decomposition:
- Shared package gpio_pkg:
  - LED mode constants: LED_STATIC=2'd0, LED_FOLLOW=2'd1, LED_BLINK=2'd2, LED_BLINK_EVT=2'd3.
  - clog2-based width helper.
- Sub-module gpio_debounce:
  - One channel: synchroniser, debounce counter, state, rise/fall.
  - Instantiated NUM_CH times via generate.
- Blink, sticky-event and LED mux logic stay in the top module.

Test Plan (sim params NUM_CH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, BLINK_HALF_PERIOD=3):
- Reset: hold reset, gpio_switch=4'hF -> all outputs 0. Release reset -> all outputs still 0 through the release sync. sw_state=4'hF on edge #(2+2+4) after release, with sw_rise=4'hF for exactly that one cycle.
- Debounce/glitch: ch0 0->1 stable -> sw_state[0]=1 exactly 6 edges after first sample. Ch1 1-cycle and 3-cycle pulses -> sw_state[1] stays 0, no sw_rise[1].
- Sticky event: ch2 rise sets sw_event[2]=1. event_clear[2]=1 alone clears it. A clear pulse in the same cycle as sw_fall[2] leaves sw_event[2]=1.
- LED modes: led_mode={3,2,1,0}, led_value=4'h1.
  - gpio_led[0]=1 constant.
  - gpio_led[1] tracks sw_state[1] with 1-cycle lag.
  - gpio_led[2] toggles every 3 cycles, starting 0.
  - gpio_led[3] blinks only while sw_event[3]=1.
- Reset mid-operation: assert reset 2 cycles into a debounce and mid-blink phase -> all outputs 0 immediately (asynchronous). After release, no stray pulses; blink restarts at phase 0.

Source files
------------

// File: rtl/gpio_pkg.sv
// Shared constants and helpers for the switch/LED I/O block.
package gpio_pkg;

  localparam logic [1:0] LED_STATIC    = 2'd0;
  localparam logic [1:0] LED_FOLLOW    = 2'd1;
  localparam logic [1:0] LED_BLINK     = 2'd2;
  localparam logic [1:0] LED_BLINK_EVT = 2'd3;

  // Width of a counter that must hold values 0..max_count without wrapping.
  function automatic int unsigned cnt_width(input int unsigned max_count);
    return $clog2(max_count) + 32'd1;
  endfunction

endpackage

// File: rtl/gpio_debounce.sv
// One switch channel: input synchroniser, stable-cycle debounce counter,
// accepted level and registered rise/fall pulses.
module gpio_debounce
  import gpio_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sw_i,
  output logic state_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned       CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]     CNT_LAST = CW'(DEBOUNCE_CYCLES - 32'd1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   state_q, state_d;
  logic                   rise_q, fall_q;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  // Count consecutive cycles the synchronised level disagrees with the state.
  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    if (synced == state_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      state_d = synced;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Pulses are derived from state_d so they coincide with the new level.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      state_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], sw_i};
      cnt_q   <= cnt_d;
      state_q <= state_d;
      rise_q  <= state_d & ~state_q;
      fall_q  <= ~state_d & state_q;
    end
  end

  assign state_o = state_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/gpio_io_ctrl.sv
// Board switch/LED path: debounced switches with edge pulses and sticky
// events, plus per-channel LED drive (static, follow, blink, blink-on-event).
module gpio_io_ctrl
  import gpio_pkg::*;
#(
  parameter int unsigned NUM_CH            = 4,
  parameter int unsigned SYNC_STAGES       = 2,
  parameter int unsigned DEBOUNCE_CYCLES   = 100000,
  parameter int unsigned BLINK_HALF_PERIOD = 25000000
) (
  input  logic                  SYSTEMCLOCK,
  input  logic                  PUSH_BUTTON_RESET_RAW,
  input  logic [NUM_CH-1:0]     gpio_switch,
  input  logic [NUM_CH-1:0]     event_clear,
  input  logic [2*NUM_CH-1:0]   led_mode,
  input  logic [NUM_CH-1:0]     led_value,
  output logic [NUM_CH-1:0]     sw_state,
  output logic [NUM_CH-1:0]     sw_rise,
  output logic [NUM_CH-1:0]     sw_fall,
  output logic [NUM_CH-1:0]     sw_event,
  output logic [NUM_CH-1:0]     gpio_led
);

  if (NUM_CH < 32'd1 || NUM_CH > 32'd32) begin : g_bad_num_ch
    $error("gpio_io_ctrl: NUM_CH must be within 1..32");
  end
  if (SYNC_STAGES < 32'd2) begin : g_bad_sync
    $error("gpio_io_ctrl: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 32'd1) begin : g_bad_debounce
    $error("gpio_io_ctrl: DEBOUNCE_CYCLES must be >= 1");
  end
  if (BLINK_HALF_PERIOD < 32'd1) begin : g_bad_blink
    $error("gpio_io_ctrl: BLINK_HALF_PERIOD must be >= 1");
  end

  localparam int unsigned   BW         = cnt_width(BLINK_HALF_PERIOD);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF_PERIOD - 32'd1);

  logic [1:0]        rst_sync_q;
  logic              rst_int;
  logic [BW-1:0]     blink_cnt_q;
  logic              phase_q;
  logic [NUM_CH-1:0] event_q, event_d;
  logic [NUM_CH-1:0] led_q, led_d;

  // Assert immediately, release only after two clean clock edges.
  always_ff @(posedge SYSTEMCLOCK or posedge PUSH_BUTTON_RESET_RAW) begin
    if (PUSH_BUTTON_RESET_RAW) begin
      rst_sync_q <= 2'b11;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b0};
    end
  end

  assign rst_int = rst_sync_q[1];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    gpio_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk_i   (SYSTEMCLOCK),
      .rst_i   (rst_int),
      .sw_i    (gpio_switch[i]),
      .state_o (sw_state[i]),
      .rise_o  (sw_rise[i]),
      .fall_o  (sw_fall[i])
    );
  end

  // Sticky events (a new edge beats a simultaneous clear) and LED selection.
  always_comb begin
    event_d = (event_q & ~event_clear) | sw_rise | sw_fall;
    led_d   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      case (led_mode[2*i +: 2])
        LED_STATIC:    led_d[i] = led_value[i];
        LED_FOLLOW:    led_d[i] = sw_state[i];
        LED_BLINK:     led_d[i] = phase_q;
        LED_BLINK_EVT: led_d[i] = phase_q & event_q[i];
        default:       led_d[i] = 1'b0;
      endcase
    end
  end

  // Shared blink timebase keeps every blinking channel in phase.
  always_ff @(posedge SYSTEMCLOCK or posedge rst_int) begin
    if (rst_int) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      event_q     <= '0;
      led_q       <= '0;
    end else begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_q <= '0;
        phase_q     <= ~phase_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 1'b1;
      end
      event_q <= event_d;
      led_q   <= led_d;
    end
  end

  assign sw_event = event_q;
  assign gpio_led = led_q;

endmodule
